rfphoenix_pma_checker: RTL and testbench
========================================

# rfPhoenix_pma_checker

Parametrised, pipelined physical-memory-attribute checker for rfPhoenix. It maps a physical address to one of `NREGIONS` configurable regions and checks the requested access type against that region's attributes. Each lookup gets a registered two-stage response with valid/ready backpressure. A faulting lookup records its address in a sticky fault register. The block sits between the MMU/TLB output and the bus interface unit, and its configuration registers are reached through the CSR path.

## Interface
Parameters:
- `NREGIONS`, default 8: number of regions; a power of two, 2..16.
- `AWID`, default 48: physical address width.
- `GRAN`, default 4: number of low address bits ignored during compare (16-byte granule).

Ports:
- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: lookup request valid.
- `req_ready` out 1: lookup request accepted this cycle.
- `req_adr` in `AWID`: physical address to look up.
- `req_acc` in 3: requested access, {R,W,X}; more than one bit may be set.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_region_num` out 4: index of the matched region.
- `rsp_at` out 20: attribute field of the matched region.
- `rsp_nomatch` out 1: no region matched.
- `rsp_err` out 1: no match, or the requested access is denied.
- `cfg_wr` in 1: configuration write strobe.
- `cfg_rd` in 1: configuration read strobe.
- `cfg_adr` in `$clog2(NREGIONS)+4`: {region, field[3:0]}.
- `cfg_dat_i` in 32: configuration write data.
- `cfg_dat_o` out 32: configuration read data.
- `cfg_ack` out 1: one-cycle acknowledge.
- `fault_o` out 1: sticky fault flag.

## Operation
- Region record fields:
  - `start`, `nd`, `pmt`, `cta`: `AWID` bits each.
  - `at`: 20 bits. `at[0]`=X, `at[1]`=W, `at[2]`=R, `at[3]`=cacheable.
  - `lock`: 32 bits. "LOCK" = 32'h4C4F434B; "UNLK" = 32'h554E4C4B.
- Match rule: `adr[AWID-1:GRAN] >= start[AWID-1:GRAN]` and `adr[AWID-1:GRAN] <= nd[AWID-1:GRAN]`.
- Priority: the highest-numbered matching region wins.
- No match: `rsp_region_num`=0, `rsp_at`=0, `rsp_nomatch`=1, `rsp_err`=1.
- Denial: `rsp_err`=1 if any requested bit in `req_acc` lacks its permission bit in `at`. `req_acc`=0 never errs on a matched region.
- Config fields (`cfg_adr[3:0]`):
  - 0/1: `start` low 32 bits / high `AWID-32` bits.
  - 2/3: `nd` low / high.
  - 4/5: `pmt` low / high.
  - 6/7: `cta` low / high.
  - 8: `at`.
  - 14: `lock`.
  - 15: reads `fault_adr[31:0]`; a write to field 15 clears `fault_o`, irrespective of lock.
  - 9–13: read 0, writes ignored.
- Write gating: fields 0–8 are writable only when that region's `lock` equals "UNLK". Field 14 is always writable. Blocked writes are still acked.
- Fault capture: on the first `rsp_err` while `fault_o`=0, capture `fault_adr`, `fault_acc` and `fault_nomatch`. Later faults are ignored until cleared.

## Timing
- Pipeline: S1 = compare, priority encode, and latch of the selected record's `at` and index. S2 = permission check, fault capture, output register. Latency is 2 cycles from acceptance to `rsp_valid`.
- `advance` = !`s2_valid` | `rsp_ready`; `req_ready` = `advance`. Both stages hold when `advance`=0. Throughput is one lookup per cycle.
- A request is sampled against the region table in the cycle it is accepted. A config write in that same cycle is not visible to it; it is visible to the next accepted request.
- Config: `cfg_ack` and `cfg_dat_o` are registered one cycle after `cfg_wr` or `cfg_rd`. Simultaneous `cfg_wr` and `cfg_rd`: the write takes effect and the read returns the pre-write value.
- Fault: a clear and a new fault in the same cycle: the new fault wins, so `fault_o` stays 1 with the new address.
- Reset (async assert, sync deassert handled upstream):
  - All pipeline valids, `rsp_*`, `cfg_ack`, `cfg_dat_o` and `fault_o` go to 0.
  - The region table loads `PMA_RESET_TABLE`.
  - A reset mid-lookup discards in-flight requests; no response is issued.
- `req_ready` is 0 during reset.

## Structure
- Shared package `rfPhoenixMmupkg`:
  - `REGION` struct.
  - `PMA_LOCK`/`PMA_UNLK` constants.
  - `PMA_AT_X/W/R/C` bit indices.
  - `PMA_RESET_TABLE`: ROM FFFD0000–FFFFFFFF at 0D; IO FF800000–FF9FFFFF at 206; scratchpad FFFC0000–FFFCFFFF at 20F; DRAM 0–1FFFFFFF at 10F; vacant regions FFFFFFFF at FF00. All regions locked.
- One sub-module, `rfPhoenix_pma_prio_enc`: a parametrised highest-index priority encoder producing {found, index}.

## Test plan
- Reset defaults:
  - `req_adr`=FFFE0000, acc=R → region 7, `at`=0D, `err`=0, 2 cycles after acceptance.
  - acc=W at the same address → `err`=1 and `fault_o`=1.
- Gap address: `req_adr`=20000000 → `rsp_nomatch`=1, `err`=1. Field-15 read returns 20000000; a field-15 write clears `fault_o`.
- Lock:
  - Write field 0 of region 2 while locked → ack, value unchanged.
  - Write field 14 = "UNLK", then field 0 = 20000000 and field 2 = 2000FFFF.
  - Lookup 20000010 → region 2, `at`=0FF00.
- Overlap priority: set region 5 to 0–FFFF → address 100 returns region 5, not region 1.
- Backpressure: a stream of 4 back-to-back requests with `rsp_ready` low for 3 cycles → `req_ready` drops, no loss or reordering, 4 responses in order.
- Mid-flight reset: assert `rst_n` low with 2 lookups in flight → no `rsp_valid` after release, and the table is back at defaults.

Source files
------------

// File: rtl/rfphoenix_pma_checker_pkg.sv
// rfPhoenixMmupkg: definitions shared by the PMA checker and its users.
//   REGION          - one region record (address bounds, attributes, lock word)
//   PMA_LOCK/UNLK   - lock-word values; fields 0-8 are writable only when UNLK
//   PMA_AT_*        - bit positions of X/W/R/cacheable inside the attribute field
//   PMA_RESET_TABLE - the eight-entry table loaded on reset (index 0 rightmost)
package rfPhoenixMmupkg;

   localparam int PMA_AWID = 48;

   localparam logic [31:0] PMA_LOCK = 32'h4C4F434B;
   localparam logic [31:0] PMA_UNLK = 32'h554E4C4B;

   localparam int PMA_AT_X = 0;
   localparam int PMA_AT_W = 1;
   localparam int PMA_AT_R = 2;
   localparam int PMA_AT_C = 3;

   localparam int PMA_RESET_REGIONS = 8;

   typedef struct packed {
      logic [PMA_AWID-1:0] start;
      logic [PMA_AWID-1:0] nd;
      logic [PMA_AWID-1:0] pmt;
      logic [PMA_AWID-1:0] cta;
      logic [19:0]         at;
      logic [31:0]         lock;
   } REGION;

   function automatic REGION pma_region(input logic [31:0] s, input logic [31:0] e,
                                        input logic [19:0] a);
      pma_region = '{start: PMA_AWID'(s), nd: PMA_AWID'(e), pmt: '0, cta: '0,
                     at: a, lock: PMA_LOCK};
   endfunction

   // Vacant entries collapse to the top granule and grant no access.
   localparam REGION PMA_VACANT = pma_region(32'hFFFFFFFF, 32'hFFFFFFFF, 20'h0FF00);

   localparam REGION [PMA_RESET_REGIONS-1:0] PMA_RESET_TABLE = {
      pma_region(32'hFFFD0000, 32'hFFFFFFFF, 20'h0000D),   // 7: boot ROM
      pma_region(32'hFFFC0000, 32'hFFFCFFFF, 20'h0020F),   // 6: scratchpad
      PMA_VACANT,                                          // 5
      pma_region(32'hFF800000, 32'hFF9FFFFF, 20'h00206),   // 4: IO
      PMA_VACANT,                                          // 3
      PMA_VACANT,                                          // 2
      pma_region(32'h00000000, 32'h1FFFFFFF, 20'h0010F),   // 1: DRAM
      PMA_VACANT                                           // 0
   };

endpackage

// File: rtl/rfphoenix_pma_checker_prio_enc.sv
// rfPhoenix_pma_prio_enc: highest-index-wins priority encoder.
//   req_i   - one request bit per region
//   found_o - at least one bit of req_i is set
//   idx_o   - index of the highest set bit (0 when none)
module rfPhoenix_pma_prio_enc #(
   parameter int N  = 8,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   output logic          found_o,
   output logic [IW-1:0] idx_o
);

   // Ascending scan: a later (higher) hit overwrites an earlier one.
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      for (int i = 0; i < N; i++) begin
         if (req_i[i]) begin
            found_o = 1'b1;
            idx_o   = i[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/rfphoenix_pma_checker.sv
// rfphoenix_pma_checker: two-stage physical-memory-attribute lookup.
//   req_*      - lookup request (address, {R,W,X} access) with valid/ready
//   rsp_*      - registered response: region index, attributes, nomatch, err
//   cfg_*      - CSR access to the region table, {region, field} addressing,
//                registered read data and one-cycle ack
//   fault_o    - sticky flag set by the first erring lookup, cleared by a
//                write to field 15 of any region
module rfphoenix_pma_checker
   import rfPhoenixMmupkg::*;
#(
   parameter int NREGIONS = 8,
   parameter int AWID     = 48,
   parameter int GRAN     = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [AWID-1:0]               req_adr,
   input  logic [2:0]                    req_acc,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [3:0]                    rsp_region_num,
   output logic [19:0]                   rsp_at,
   output logic                          rsp_nomatch,
   output logic                          rsp_err,
   input  logic                          cfg_wr,
   input  logic                          cfg_rd,
   input  logic [$clog2(NREGIONS)+3:0]   cfg_adr,
   input  logic [31:0]                   cfg_dat_i,
   output logic [31:0]                   cfg_dat_o,
   output logic                          cfg_ack,
   output logic                          fault_o
);

   localparam int RW = $clog2(NREGIONS);
   localparam int HW = AWID - 32;

   logic [AWID-1:0] start_q [NREGIONS];
   logic [AWID-1:0] nd_q    [NREGIONS];
   logic [AWID-1:0] pmt_q   [NREGIONS];
   logic [AWID-1:0] cta_q   [NREGIONS];
   logic [19:0]     at_q    [NREGIONS];
   logic [31:0]     lock_q  [NREGIONS];
   REGION           rst_tbl [NREGIONS];

   for (genvar g = 0; g < NREGIONS; g++) begin : g_rst
      if (g < PMA_RESET_REGIONS) begin : g_tbl
         assign rst_tbl[g] = PMA_RESET_TABLE[g];
      end else begin : g_vac
         assign rst_tbl[g] = PMA_VACANT;
      end
   end

   logic [RW-1:0] cfg_rgn;
   logic [3:0]    cfg_fld;
   logic          wr_open;
   logic          fault_clr;
   assign cfg_rgn   = cfg_adr[RW+3:4];
   assign cfg_fld   = cfg_adr[3:0];
   assign wr_open   = (lock_q[cfg_rgn] == PMA_UNLK);
   assign fault_clr = cfg_wr && (cfg_fld == 4'd15);

   logic          s1_vld_q;
   logic          rsp_valid_q;
   logic          advance;
   logic          accept;
   assign advance   = !rsp_valid_q || rsp_ready;
   assign req_ready = advance && rst_n;
   assign accept    = req_valid && req_ready;

   // Region table: reset image, gated CSR writes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGIONS; i++) begin
            start_q[i] <= AWID'(rst_tbl[i].start);
            nd_q[i]    <= AWID'(rst_tbl[i].nd);
            pmt_q[i]   <= AWID'(rst_tbl[i].pmt);
            cta_q[i]   <= AWID'(rst_tbl[i].cta);
            at_q[i]    <= rst_tbl[i].at;
            lock_q[i]  <= rst_tbl[i].lock;
         end
      end else if (cfg_wr) begin
         case (cfg_fld)
            4'd0:  if (wr_open) start_q[cfg_rgn][31:0]     <= cfg_dat_i;
            4'd1:  if (wr_open) start_q[cfg_rgn][AWID-1:32] <= cfg_dat_i[HW-1:0];
            4'd2:  if (wr_open) nd_q[cfg_rgn][31:0]        <= cfg_dat_i;
            4'd3:  if (wr_open) nd_q[cfg_rgn][AWID-1:32]   <= cfg_dat_i[HW-1:0];
            4'd4:  if (wr_open) pmt_q[cfg_rgn][31:0]       <= cfg_dat_i;
            4'd5:  if (wr_open) pmt_q[cfg_rgn][AWID-1:32]  <= cfg_dat_i[HW-1:0];
            4'd6:  if (wr_open) cta_q[cfg_rgn][31:0]       <= cfg_dat_i;
            4'd7:  if (wr_open) cta_q[cfg_rgn][AWID-1:32]  <= cfg_dat_i[HW-1:0];
            4'd8:  if (wr_open) at_q[cfg_rgn]              <= cfg_dat_i[19:0];
            4'd14: lock_q[cfg_rgn] <= cfg_dat_i;
            default: ;
         endcase
      end
   end

   logic [AWID-1:0] fault_adr_q;
   logic [2:0]      fault_acc_q;
   logic            fault_nomatch_q;
   logic            fault_q;

   // Read mux sees the table before any same-cycle write lands.
   logic [31:0] rd_dat;
   always_comb begin
      rd_dat = '0;
      case (cfg_fld)
         4'd0:  rd_dat = start_q[cfg_rgn][31:0];
         4'd1:  rd_dat = 32'(start_q[cfg_rgn][AWID-1:32]);
         4'd2:  rd_dat = nd_q[cfg_rgn][31:0];
         4'd3:  rd_dat = 32'(nd_q[cfg_rgn][AWID-1:32]);
         4'd4:  rd_dat = pmt_q[cfg_rgn][31:0];
         4'd5:  rd_dat = 32'(pmt_q[cfg_rgn][AWID-1:32]);
         4'd6:  rd_dat = cta_q[cfg_rgn][31:0];
         4'd7:  rd_dat = 32'(cta_q[cfg_rgn][AWID-1:32]);
         4'd8:  rd_dat = 32'(at_q[cfg_rgn]);
         4'd14: rd_dat = lock_q[cfg_rgn];
         4'd15: rd_dat = fault_adr_q[31:0];
         default: rd_dat = '0;
      endcase
   end

   logic        cfg_ack_q;
   logic [31:0] cfg_dat_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_ack_q <= 1'b0;
         cfg_dat_q <= '0;
      end else begin
         cfg_ack_q <= cfg_wr || cfg_rd;
         if (cfg_rd) cfg_dat_q <= rd_dat;
      end
   end

   logic [NREGIONS-1:0] hit;
   always_comb begin
      hit = '0;
      for (int i = 0; i < NREGIONS; i++) begin
         hit[i] = (req_adr[AWID-1:GRAN] >= start_q[i][AWID-1:GRAN]) &&
                  (req_adr[AWID-1:GRAN] <= nd_q[i][AWID-1:GRAN]);
      end
   end

   logic          found;
   logic [RW-1:0] found_idx;
   rfPhoenix_pma_prio_enc #(.N(NREGIONS), .IW(RW)) u_prio (
      .req_i   (hit),
      .found_o (found),
      .idx_o   (found_idx)
   );

   // S1: compare, priority encode, latch winning record
   logic [AWID-1:0] s1_adr_q;
   logic [2:0]      s1_acc_q;
   logic [19:0]     s1_at_q;
   logic [RW-1:0]   s1_idx_q;
   logic            s1_nomatch_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) s1_vld_q <= 1'b0;
      else if (advance) s1_vld_q <= accept;
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         s1_adr_q     <= req_adr;
         s1_acc_q     <= req_acc;
         s1_at_q      <= found ? at_q[found_idx] : '0;
         s1_idx_q     <= found_idx;
         s1_nomatch_q <= !found;
      end
   end

   // S2: permission check, fault capture, output register
   logic s2_err;
   assign s2_err = s1_nomatch_q ||
                   |(s1_acc_q & ~{s1_at_q[PMA_AT_R], s1_at_q[PMA_AT_W], s1_at_q[PMA_AT_X]});

   logic [3:0]  rsp_region_q;
   logic [19:0] rsp_at_q;
   logic        rsp_nomatch_q;
   logic        rsp_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q   <= 1'b0;
         rsp_region_q  <= '0;
         rsp_at_q      <= '0;
         rsp_nomatch_q <= 1'b0;
         rsp_err_q     <= 1'b0;
      end else if (advance) begin
         rsp_valid_q <= s1_vld_q;
         if (s1_vld_q) begin
            rsp_region_q  <= 4'(s1_idx_q);
            rsp_at_q      <= s1_at_q;
            rsp_nomatch_q <= s1_nomatch_q;
            rsp_err_q     <= s2_err;
         end
      end
   end

   // A clear arriving with a new fault still leaves the new fault recorded.
   logic fault_set;
   assign fault_set = advance && s1_vld_q && s2_err && (!fault_q || fault_clr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault_q         <= 1'b0;
         fault_adr_q     <= '0;
         fault_acc_q     <= '0;
         fault_nomatch_q <= 1'b0;
      end else if (fault_set) begin
         fault_q         <= 1'b1;
         fault_adr_q     <= s1_adr_q;
         fault_acc_q     <= s1_acc_q;
         fault_nomatch_q <= s1_nomatch_q;
      end else if (fault_clr) begin
         fault_q <= 1'b0;
      end
   end

   // Captured fault details beyond field 15 have no read path yet.
   logic unused_fault;
   assign unused_fault = ^{fault_adr_q[AWID-1:32], fault_acc_q, fault_nomatch_q};

   assign rsp_valid      = rsp_valid_q;
   assign rsp_region_num = rsp_region_q;
   assign rsp_at         = rsp_at_q;
   assign rsp_nomatch    = rsp_nomatch_q;
   assign rsp_err        = rsp_err_q;
   assign cfg_ack        = cfg_ack_q;
   assign cfg_dat_o      = cfg_dat_q;
   assign fault_o        = fault_q;

endmodule

// File: tb/tb_rfphoenix_pma_checker.sv
module tb_rfphoenix_pma_checker;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [47:0] req_adr = '0;
   logic [2:0]  req_acc = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [3:0]  rsp_region_num;
   logic [19:0] rsp_at;
   logic        rsp_nomatch;
   logic        rsp_err;
   logic        cfg_wr = 1'b0;
   logic        cfg_rd = 1'b0;
   logic [6:0]  cfg_adr = '0;
   logic [31:0] cfg_dat_i = '0;
   logic [31:0] cfg_dat_o;
   logic        cfg_ack;
   logic        fault_o;

   always #5 clk = ~clk;

   rfphoenix_pma_checker #(.NREGIONS(8), .AWID(48), .GRAN(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_adr(req_adr), .req_acc(req_acc),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_region_num(rsp_region_num),
      .rsp_at(rsp_at), .rsp_nomatch(rsp_nomatch), .rsp_err(rsp_err),
      .cfg_wr(cfg_wr), .cfg_rd(cfg_rd), .cfg_adr(cfg_adr), .cfg_dat_i(cfg_dat_i),
      .cfg_dat_o(cfg_dat_o), .cfg_ack(cfg_ack), .fault_o(fault_o)
   );

   int n_cmp = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic cfg_write(input int rgn, input int fld, input logic [31:0] dat);
      @(negedge clk);
      cfg_wr = 1'b1; cfg_adr = {rgn[2:0], fld[3:0]}; cfg_dat_i = dat;
      @(negedge clk);
      cfg_wr = 1'b0;
      check($sformatf("cfg_wr_ack r%0d f%0d", rgn, fld), 64'(cfg_ack), 64'd1);
   endtask

   task automatic cfg_read(input int rgn, input int fld, output logic [31:0] dat);
      @(negedge clk);
      cfg_rd = 1'b1; cfg_adr = {rgn[2:0], fld[3:0]};
      @(negedge clk);
      cfg_rd = 1'b0;
      check($sformatf("cfg_rd_ack r%0d f%0d", rgn, fld), 64'(cfg_ack), 64'd1);
      dat = cfg_dat_o;
   endtask

   // Issue one lookup with rsp_ready high; lat counts falling edges from the
   // accepting rising edge until rsp_valid is seen (2 expected).
   task automatic lookup(input logic [47:0] adr, input logic [2:0] acc,
                         output logic [3:0] rgn, output logic [19:0] at,
                         output logic nm, output logic err, output int lat);
      int n;
      @(negedge clk);
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_adr = adr; req_acc = acc;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      rgn = rsp_region_num; at = rsp_at; nm = rsp_nomatch; err = rsp_err;
   endtask

   typedef struct {
      logic [47:0] adr;
      logic [2:0]  acc;
      logic [3:0]  rgn;
      logic [19:0] at;
      logic        nm;
      logic        err;
   } vec_t;

   vec_t vecs [18];

   logic [3:0]  g_rgn;
   logic [19:0] g_at;
   logic        g_nm, g_err;
   int          g_lat;
   logic [31:0] rd;

   task automatic check_lookup(input string tag, input logic [47:0] adr, input logic [2:0] acc,
                               input logic [3:0] rgn, input logic [19:0] at,
                               input logic nm, input logic err);
      lookup(adr, acc, g_rgn, g_at, g_nm, g_err, g_lat);
      check({tag, " latency"}, 64'(g_lat), 64'd2);
      check({tag, " region"}, 64'(g_rgn), 64'(rgn));
      check({tag, " at"}, 64'(g_at), 64'(at));
      check({tag, " nomatch"}, 64'(g_nm), 64'(nm));
      check({tag, " err"}, 64'(g_err), 64'(err));
   endtask

   logic [47:0] adr_bp [4];
   logic [3:0]  exp_bp [4];
   logic [3:0]  got_bp [4];

   initial begin
      vecs[0]  = '{48'hFFFE0000, 3'd4, 4'd7, 20'h0000D, 1'b0, 1'b0};
      vecs[1]  = '{48'hFFFE0000, 3'd2, 4'd7, 20'h0000D, 1'b0, 1'b1};
      vecs[2]  = '{48'hFFFE0000, 3'd1, 4'd7, 20'h0000D, 1'b0, 1'b0};
      vecs[3]  = '{48'hFFFE0000, 3'd5, 4'd7, 20'h0000D, 1'b0, 1'b0};
      vecs[4]  = '{48'hFF800000, 3'd6, 4'd4, 20'h00206, 1'b0, 1'b0};
      vecs[5]  = '{48'hFF9FFFFF, 3'd1, 4'd4, 20'h00206, 1'b0, 1'b1};
      vecs[6]  = '{48'hFFA00000, 3'd4, 4'd0, 20'h00000, 1'b1, 1'b1};
      vecs[7]  = '{48'hFFFC0000, 3'd7, 4'd6, 20'h0020F, 1'b0, 1'b0};
      vecs[8]  = '{48'hFFFCFFFF, 3'd4, 4'd6, 20'h0020F, 1'b0, 1'b0};
      vecs[9]  = '{48'hFFFD0000, 3'd4, 4'd7, 20'h0000D, 1'b0, 1'b0};
      vecs[10] = '{48'h00000000, 3'd4, 4'd1, 20'h0010F, 1'b0, 1'b0};
      vecs[11] = '{48'h1FFFFFFF, 3'd2, 4'd1, 20'h0010F, 1'b0, 1'b0};
      vecs[12] = '{48'h20000000, 3'd4, 4'd0, 20'h00000, 1'b1, 1'b1};
      vecs[13] = '{48'hFFFFFFFF, 3'd4, 4'd7, 20'h0000D, 1'b0, 1'b0};
      vecs[14] = '{48'hFFA00000, 3'd0, 4'd0, 20'h00000, 1'b1, 1'b1};
      vecs[15] = '{48'hFFFE0000, 3'd0, 4'd7, 20'h0000D, 1'b0, 1'b0};
      vecs[16] = '{48'h000100000000, 3'd4, 4'd0, 20'h00000, 1'b1, 1'b1};
      vecs[17] = '{48'hFFFBFFFF, 3'd4, 4'd0, 20'h00000, 1'b1, 1'b1};

      // reset state
      repeat (3) @(negedge clk);
      #1;
      check("reset rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset req_ready", 64'(req_ready), 64'd0);
      check("reset fault_o", 64'(fault_o), 64'd0);
      check("reset cfg_ack", 64'(cfg_ack), 64'd0);
      check("reset cfg_dat_o", 64'(cfg_dat_o), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post-reset req_ready", 64'(req_ready), 64'd1);

      // default table
      for (int i = 0; i < 18; i++)
         check_lookup($sformatf("vec%0d", i), vecs[i].adr, vecs[i].acc, vecs[i].rgn,
                      vecs[i].at, vecs[i].nm, vecs[i].err);
      check("fault after table", 64'(fault_o), 64'd1);
      cfg_read(0, 15, rd);
      check("first fault adr", 64'(rd), 64'hFFFE0000);

      // fault clear, capture, stickiness
      cfg_write(0, 15, 32'h0);
      check("fault cleared", 64'(fault_o), 64'd0);
      check_lookup("gap", 48'h20000000, 3'd4, 4'd0, 20'h0, 1'b1, 1'b1);
      check("gap fault_o", 64'(fault_o), 64'd1);
      cfg_read(3, 15, rd);
      check("gap fault adr", 64'(rd), 64'h20000000);
      check_lookup("second fault", 48'hFFA00000, 3'd4, 4'd0, 20'h0, 1'b1, 1'b1);
      cfg_read(0, 15, rd);
      check("sticky fault adr", 64'(rd), 64'h20000000);

      // clear and new fault on the same edge
      @(negedge clk);
      req_valid = 1'b1; req_adr = 48'hFF900000; req_acc = 3'd1;
      @(negedge clk);
      req_valid = 1'b0;
      cfg_wr = 1'b1; cfg_adr = {3'd0, 4'd15}; cfg_dat_i = 32'h0;
      @(negedge clk);
      cfg_wr = 1'b0;
      check("clr+fault fault_o", 64'(fault_o), 64'd1);
      cfg_read(0, 15, rd);
      check("clr+fault adr", 64'(rd), 64'hFF900000);
      cfg_write(0, 15, 32'h0);
      check("fault cleared again", 64'(fault_o), 64'd0);

      // lock gating
      cfg_write(2, 0, 32'h20000000);
      cfg_read(2, 0, rd);
      check("locked write blocked", 64'(rd), 64'hFFFFFFFF);
      cfg_write(2, 14, 32'h554E4C4B);
      cfg_read(2, 14, rd);
      check("lock readback", 64'(rd), 64'h554E4C4B);
      cfg_write(2, 0, 32'h20000000);
      cfg_write(2, 2, 32'h2000FFFF);
      cfg_read(2, 0, rd);
      check("unlocked start", 64'(rd), 64'h20000000);
      cfg_read(2, 9, rd);
      check("field9 reads 0", 64'(rd), 64'h0);
      cfg_read(7, 3, rd);
      check("rom nd high", 64'(rd), 64'h0);
      check_lookup("region2", 48'h20000010, 3'd4, 4'd2, 20'h0FF00, 1'b0, 1'b1);

      // simultaneous write and read return the old value
      @(negedge clk);
      cfg_wr = 1'b1; cfg_rd = 1'b1; cfg_adr = {3'd2, 4'd0}; cfg_dat_i = 32'h21000000;
      @(negedge clk);
      cfg_wr = 1'b0; cfg_rd = 1'b0;
      check("wr+rd old value", 64'(cfg_dat_o), 64'h20000000);
      cfg_read(2, 0, rd);
      check("wr+rd new value", 64'(rd), 64'h21000000);

      // overlap priority
      cfg_write(5, 14, 32'h554E4C4B);
      cfg_write(5, 0, 32'h00000000);
      cfg_write(5, 2, 32'h0000FFFF);
      cfg_write(5, 8, 32'h00000007);
      check_lookup("overlap", 48'h00000100, 3'd4, 4'd5, 20'h00007, 1'b0, 1'b0);
      check_lookup("past overlap", 48'h00010000, 3'd4, 4'd1, 20'h0010F, 1'b0, 1'b0);

      // backpressure: four back-to-back requests, consumer stalled 3 cycles
      adr_bp = '{48'hFFFE0000, 48'hFF800000, 48'hFFFC0000, 48'h00000100};
      exp_bp = '{4'd7, 4'd4, 4'd6, 4'd5};
      begin
         int sent, got;
         bit saw_low, acc_now, rsp_now;
         sent = 0; got = 0; saw_low = 0;
         @(negedge clk);
         req_valid = 1'b1; req_adr = adr_bp[0]; req_acc = 3'd4;
         for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            rsp_ready = (cyc >= 3);
            #1;
            acc_now = req_valid && req_ready;
            rsp_now = rsp_valid && rsp_ready;
            if (!req_ready) saw_low = 1;
            if (rsp_now) begin
               got_bp[got] = rsp_region_num;
               got++;
            end
            @(negedge clk);
            if (acc_now) begin
               sent++;
               if (sent < 4) req_adr = adr_bp[sent];
               else req_valid = 1'b0;
            end
         end
         req_valid = 1'b0;
         rsp_ready = 1'b1;
         check("bp sent", 64'(sent), 64'd4);
         check("bp received", 64'(got), 64'd4);
         check("bp req_ready dropped", 64'(saw_low), 64'd1);
         for (int i = 0; i < 4; i++)
            if (i < got) check($sformatf("bp order %0d", i), 64'(got_bp[i]), 64'(exp_bp[i]));
      end

      // reset with lookups in flight
      begin
         bit seen;
         seen = 0;
         @(negedge clk);
         req_valid = 1'b1; req_adr = 48'hFFFE0000; req_acc = 3'd4;
         @(negedge clk);
         req_adr = 48'hFF800000;
         @(negedge clk);
         req_valid = 1'b0;
         rst_n = 1'b0;
         #1;
         check("midreset rsp_valid", 64'(rsp_valid), 64'd0);
         check("midreset req_ready", 64'(req_ready), 64'd0);
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
         for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
         end
         check("no rsp after reset", 64'(seen), 64'd0);
      end
      cfg_read(2, 0, rd);
      check("table default start r2", 64'(rd), 64'hFFFFFFFF);
      cfg_read(2, 14, rd);
      check("table default lock r2", 64'(rd), 64'h4C4F434B);
      cfg_read(5, 8, rd);
      check("table default at r5", 64'(rd), 64'h0FF00);
      check_lookup("after reset", 48'h00000100, 3'd4, 4'd1, 20'h0010F, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
